btb_predictor: RTL and testbench
================================

Name: btb_predictor

Overview:
- Branch target buffer as seen from fetch: the predictor that reads stored entries, plus the update path driven from branch resolution in MEM.
- Fetch presents the current PC and gets, in the same cycle, a hit flag, a taken prediction and the next-fetch PC.
- Resolved branches train the storage:
  - per-entry 2-bit saturating counters;
  - valid bits;
  - first-invalid / round-robin allocation.

Parameters:
ENTRIES, 8, number of fully-associative entries (power of two, 2..32)
CTR_INIT, 2'b10, counter value loaded on allocation (weakly taken)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
lookup_valid  input  1  fetch is presenting a PC this cycle
lookup_pc  input  16  fetch PC (lc3b_word)
lookup_hit  output  1  valid entry tag matches lookup_pc
lookup_taken  output  1  hit and counter[1]==1
predicted_pc  output  16  next-fetch PC
update_valid  input  1  resolved branch this cycle
update_pc  input  16  PC of resolved branch
update_target  input  16  resolved target address
update_taken  input  1  branch was taken
flush  input  1  invalidate all entries

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n. On assertion:
  - all valid bits cleared;
  - all counters set to 2'b01;
  - round-robin pointer set to 0;
  - stats counters (if compiled in) set to 0.
- Outputs after reset: lookup_hit=0, lookup_taken=0, predicted_pc=lookup_pc+2.
- Tag compare: bits [15:1] of lookup_pc against stored tag. Bit 0 is ignored (word-aligned PCs).
- Lookup is combinational, zero latency. lookup_valid gates only the stats counters; outputs are always driven.
- predicted_pc:
  - lookup_taken=1: the stored target;
  - otherwise: lookup_pc+2, modulo 2^16 (0xFFFE -> 0x0000).
- Tag uniqueness: at most one entry matches any PC. The update path guarantees this by never allocating on a hit.
- Update, on a rising clk edge with update_valid=1:
  - Hit, taken: counter increments, saturating at 2'b11; stored target is overwritten with update_target.
  - Hit, not taken: counter decrements, saturating at 2'b00; target unchanged.
  - Miss, taken: allocate one entry. Its tag is update_pc[15:1], its target update_target, its counter CTR_INIT, valid=1. Victim selection:
    - lowest-index invalid entry if one exists; pointer unchanged;
    - otherwise the entry at the round-robin pointer; pointer then increments, wrapping ENTRIES-1 -> 0.
  - Miss, not taken: no state change.
- Read-before-write: a lookup and an update to the same PC in the same cycle return pre-update state. The update is visible on the next cycle.
- flush=1 at a clock edge:
  - all valid bits cleared;
  - counters and pointer unchanged.
  - flush wins over a simultaneous update: that update is discarded.
- Reset mid-update: reset wins; no partial write survives.
- No handshakes or stalls: an update is accepted every cycle.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined: adds output ports stat_lookups (16) and stat_hits (16).
  - stat_lookups increments on each clock edge with lookup_valid=1.
  - stat_hits increments when lookup_valid=1 and lookup_hit=1.
  - Both saturate at 0xFFFF.
  - Cleared only by reset, not by flush.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then lookup_pc=0x3000 -> lookup_hit=0, lookup_taken=0, predicted_pc=0x3002. Lookup_pc=0xFFFE -> predicted_pc=0x0000.
2. Update pc=0x3000, target=0x3040, taken=1. Next cycle lookup 0x3000 -> hit=1, taken=1 (counter 2'b10), predicted_pc=0x3040. Lookup 0x3001 gives the same result (bit 0 ignored).
3. Two not-taken updates to 0x3000 -> counter 2'b00, lookup taken=0, predicted_pc=0x3002, hit=1. Three taken updates -> counter 2'b11, saturates; a fourth taken update leaves it 2'b11.
4. ENTRIES=8: taken updates for PCs 0x1000..0x100E (step 2) fill entries 0..7 and the pointer stays 0. Taken update 0x2000 replaces entry 0 (0x1000 now misses) and the pointer becomes 1. Taken update 0x2002 replaces entry 1.
5. Lookup 0x3000 in the same cycle as its first taken update -> hit=0 that cycle, hit=1 next cycle. flush asserted together with update 0x4000 taken -> all entries miss and 0x4000 is not allocated.
6. With BTB_STATS_EN: 10 lookups, 4 of them hits -> stat_lookups=10, stat_hits=4. Flush leaves both values unchanged. Forcing stat_lookups to 0xFFFF and doing one more lookup leaves it at 0xFFFF.

Source files
------------

// File: rtl/btb_predictor.sv
// Fully-associative branch target buffer: combinational fetch lookup plus MEM-stage training.
// Optional BTB_STATS_EN adds saturating lookup/hit counters (stat_lookups, stat_hits).
module btb_predictor #(
    parameter int unsigned ENTRIES  = 8,
    parameter logic [1:0]  CTR_INIT = 2'b10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lookup_valid,
    input  logic [15:0] lookup_pc,
    output logic        lookup_hit,
    output logic        lookup_taken,
    output logic [15:0] predicted_pc,
    input  logic        update_valid,
    input  logic [15:0] update_pc,
    input  logic [15:0] update_target,
    input  logic        update_taken,
    input  logic        flush
`ifdef BTB_STATS_EN
    ,
    output logic [15:0] stat_lookups,
    output logic [15:0] stat_hits
`endif
);

    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] valid_q;
    logic [14:0]        tag_q    [ENTRIES];
    logic [15:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [IDX_W-1:0]   ptr_q;

    logic             lk_hit;
    logic [IDX_W-1:0] lk_idx;
    logic             up_hit;
    logic [IDX_W-1:0] up_idx;
    logic             inv_found;
    logic [IDX_W-1:0] inv_idx;
    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] ptr_next;

    // Tags are unique, so at most one entry matches; a plain OR-style scan suffices.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == lookup_pc[15:1])) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
        end
    end

    assign lookup_hit   = lk_hit;
    assign lookup_taken = lk_hit && ctr_q[lk_idx][1];
    assign predicted_pc = lookup_taken ? target_q[lk_idx] : lookup_pc + 16'd2;

    always_comb begin
        up_hit    = 1'b0;
        up_idx    = '0;
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == update_pc[15:1])) begin
                up_hit = 1'b1;
                up_idx = IDX_W'(i);
            end
            if (!valid_q[i] && !inv_found) begin
                inv_found = 1'b1;
                inv_idx   = IDX_W'(i);
            end
        end
    end

    assign alloc_idx = inv_found ? inv_idx : ptr_q;
    assign ptr_next  = (ptr_q == IDX_W'(ENTRIES - 1)) ? '0 : ptr_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            ptr_q   <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (update_valid) begin
            if (up_hit) begin
                if (update_taken) begin
                    target_q[up_idx] <= update_target;
                    if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'b01;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - 2'b01;
                end
            end else if (update_taken) begin
                valid_q[alloc_idx]  <= 1'b1;
                tag_q[alloc_idx]    <= update_pc[15:1];
                target_q[alloc_idx] <= update_target;
                ctr_q[alloc_idx]    <= CTR_INIT;
                if (!inv_found) ptr_q <= ptr_next;
            end
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
        end else if (lookup_valid) begin
            if (stat_lookups != 16'hFFFF) stat_lookups <= stat_lookups + 16'd1;
            if (lk_hit && (stat_hits != 16'hFFFF)) stat_hits <= stat_hits + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: expectations are queued as each cycle is driven
// and compared at the following falling edge.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        lookup_valid;
    logic [15:0] lookup_pc;
    logic        lookup_hit;
    logic        lookup_taken;
    logic [15:0] predicted_pc;
    logic        update_valid;
    logic [15:0] update_pc;
    logic [15:0] update_target;
    logic        update_taken;
    logic        flush;
`ifdef BTB_STATS_EN
    logic [15:0] stat_lookups;
    logic [15:0] stat_hits;
`endif

    int unsigned n_total  = 0;
    int unsigned n_passed = 0;
    int unsigned exp_lookups = 0;
    int unsigned exp_hits    = 0;

    string       tag_q [$];
    logic [17:0] exp_q [$];

    btb_predictor #(.ENTRIES(8), .CTR_INIT(2'b10)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .lookup_valid  (lookup_valid),
        .lookup_pc     (lookup_pc),
        .lookup_hit    (lookup_hit),
        .lookup_taken  (lookup_taken),
        .predicted_pc  (predicted_pc),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_target (update_target),
        .update_taken  (update_taken),
        .flush         (flush)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups  (stat_lookups),
        .stat_hits     (stat_hits)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_passed++;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            string       t;
            logic [17:0] e;
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check({t, ".hit"},   {15'd0, lookup_hit},   {15'd0, e[17]});
            check({t, ".taken"}, {15'd0, lookup_taken}, {15'd0, e[16]});
            check({t, ".pc"},    predicted_pc,          e[15:0]);
        end
    end

    // One clock cycle of stimulus; optional lookup expectation is queued for the checker.
    task automatic step(input string tag, input logic chk, input logic [15:0] lpc,
                        input logic eh, input logic et, input logic [15:0] ep,
                        input logic uv, input logic [15:0] upc, input logic [15:0] utg,
                        input logic ut, input logic fl);
        lookup_valid  = chk;
        lookup_pc     = lpc;
        update_valid  = uv;
        update_pc     = upc;
        update_target = utg;
        update_taken  = ut;
        flush         = fl;
        if (chk) begin
            tag_q.push_back(tag);
            exp_q.push_back({eh, et, ep});
            exp_lookups++;
            if (eh) exp_hits++;
        end
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic look(input string tag, input logic [15:0] pc,
                        input logic eh, input logic et, input logic [15:0] ep);
        step(tag, 1'b1, pc, eh, et, ep, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [15:0] pc, input logic [15:0] tgt, input logic tk);
        step("", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, pc, tgt, tk, 1'b0);
    endtask

    task automatic do_flush();
        step("", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        lookup_valid = 1'b0; lookup_pc = 16'h0;
        update_valid = 1'b0; update_pc = 16'h0; update_target = 16'h0; update_taken = 1'b0;
        flush = 1'b0;
        #12 reset_n = 1'b1;
        @(posedge clk); #1;

        look("rst_3000", 16'h3000, 1'b0, 1'b0, 16'h3002);
        look("rst_wrap", 16'hFFFE, 1'b0, 1'b0, 16'h0000);

        upd(16'h3000, 16'h3040, 1'b1);
        look("alloc", 16'h3000, 1'b1, 1'b1, 16'h3040);
        look("bit0",  16'h3001, 1'b1, 1'b1, 16'h3040);

        upd(16'h3000, 16'h3040, 1'b0);
        upd(16'h3000, 16'h3040, 1'b0);
        look("ctr00", 16'h3000, 1'b1, 1'b0, 16'h3002);
        upd(16'h3000, 16'h3040, 1'b1);
        upd(16'h3000, 16'h3040, 1'b1);
        upd(16'h3000, 16'h3040, 1'b1);
        upd(16'h3000, 16'h3080, 1'b1);
        look("ctr11", 16'h3000, 1'b1, 1'b1, 16'h3080);
        upd(16'h3000, 16'h3000, 1'b0);
        look("sat_nt1", 16'h3000, 1'b1, 1'b1, 16'h3080);
        upd(16'h3000, 16'h3000, 1'b0);
        look("sat_nt2", 16'h3000, 1'b1, 1'b0, 16'h3002);

        do_flush();
        look("flushed", 16'h3000, 1'b0, 1'b0, 16'h3002);

        for (int i = 0; i < 8; i++)
            upd(16'h1000 + 16'(2 * i), 16'h5000 + 16'(2 * i), 1'b1);
        for (int i = 0; i < 8; i++)
            look($sformatf("fill%0d", i), 16'h1000 + 16'(2 * i), 1'b1, 1'b1, 16'h5000 + 16'(2 * i));
        upd(16'h2000, 16'h6000, 1'b1);
        look("evict0_old", 16'h1000, 1'b0, 1'b0, 16'h1002);
        look("evict0_new", 16'h2000, 1'b1, 1'b1, 16'h6000);
        look("keep1",      16'h1002, 1'b1, 1'b1, 16'h5002);
        upd(16'h2002, 16'h6002, 1'b1);
        look("evict1_old", 16'h1002, 1'b0, 1'b0, 16'h1004);
        look("evict1_new", 16'h2002, 1'b1, 1'b1, 16'h6002);
        look("keep2",      16'h1004, 1'b1, 1'b1, 16'h5004);
        upd(16'h2004, 16'h6004, 1'b1);
        look("evict2_old", 16'h1004, 1'b0, 1'b0, 16'h1006);
        look("keep0",      16'h2000, 1'b1, 1'b1, 16'h6000);

        do_flush();
        step("rbw_same", 1'b1, 16'h3000, 1'b0, 1'b0, 16'h3002, 1'b1, 16'h3000, 16'h3100, 1'b1, 1'b0);
        look("rbw_next", 16'h3000, 1'b1, 1'b1, 16'h3100);
        step("flush_upd", 1'b1, 16'h4000, 1'b0, 1'b0, 16'h4002, 1'b1, 16'h4000, 16'h4444, 1'b1, 1'b1);
        look("flush_4000", 16'h4000, 1'b0, 1'b0, 16'h4002);
        look("flush_3000", 16'h3000, 1'b0, 1'b0, 16'h3002);
        upd(16'h5000, 16'h5555, 1'b0);
        look("miss_nt", 16'h5000, 1'b0, 1'b0, 16'h5002);
        upd(16'h4000, 16'h4444, 1'b1);
        look("realloc", 16'h4000, 1'b1, 1'b1, 16'h4444);

`ifdef BTB_STATS_EN
        do_flush();
        check("stat_lookups", stat_lookups, 16'(exp_lookups));
        check("stat_hits",    stat_hits,    16'(exp_hits));
`endif

        // Reset lands while an update is held on the bus and across a clock edge.
        update_valid  = 1'b1;
        update_pc     = 16'h7000;
        update_target = 16'h7070;
        update_taken  = 1'b1;
        #2 reset_n = 1'b0;
        @(posedge clk); #2;
        update_valid = 1'b0;
        reset_n = 1'b1;
        exp_lookups = 0;
        exp_hits    = 0;
        @(posedge clk); #1;
        look("rst_mid_7000", 16'h7000, 1'b0, 1'b0, 16'h7002);
        look("rst_mid_4000", 16'h4000, 1'b0, 1'b0, 16'h4002);

`ifdef BTB_STATS_EN
        check("stat_lookups_rst", stat_lookups, 16'(exp_lookups));
        check("stat_hits_rst",    stat_hits,    16'(exp_hits));
`endif

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
